// File: rtl/rgb_lut_scan_ctrl_if.sv
// rgb_lut_scan_ctrl_if: board I/O, datapath and truth-table signals of the RGB LUT scan controller (master = controller, slave = board/datapath side)
interface rgb_lut_scan_ctrl_if;
  logic        mode;
  logic        step_btn;
  logic [1:0]  sw_a;
  logic [1:0]  sw_b;
  logic        dp_red;
  logic        dp_blue;
  logic        dp_green;
  logic [1:0]  dp_a;
  logic [1:0]  dp_b;
  logic        led_r;
  logic        led_g;
  logic        led_b;
  logic        busy;
  logic [3:0]  scan_idx;
  logic        scan_done;
  logic [15:0] tbl_red;
  logic [15:0] tbl_blue;
  logic [15:0] tbl_green;
  modport master (
    input  mode, step_btn, sw_a, sw_b, dp_red, dp_blue, dp_green,
    output dp_a, dp_b, led_r, led_g, led_b, busy, scan_idx, scan_done, tbl_red, tbl_blue, tbl_green
  );
  modport slave (
    output mode, step_btn, sw_a, sw_b, dp_red, dp_blue, dp_green,
    input  dp_a, dp_b, led_r, led_g, led_b, busy, scan_idx, scan_done, tbl_red, tbl_blue, tbl_green
  );
endinterface

// File: rtl/rgb_lut_scan_ctrl.sv
// rgb_lut_scan_ctrl: drives the a/b LED-logic datapath manually or by a 16-step scan, captures its truth table and drives the RGB LED
// Ports: clk, rst_n (async active-low), bus (rgb_lut_scan_ctrl_if.master: switches, button, datapath I/O, LED, scan status, tables)
// Option: define RGB_PWM_EN to gate the LEDs with a PWM_BITS-wide free-running counter at PWM_DUTY
module rgb_lut_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DWELL_CYCLES  = 50_000_000,
  parameter int PWM_BITS      = 8,
  parameter int PWM_DUTY      = 64
) (
  input logic clk,
  input logic rst_n,
  rgb_lut_scan_ctrl_if.master bus
);
  localparam int MAXC = SETTLE_CYCLES > DWELL_CYCLES ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  if (SETTLE_CYCLES < 1 || DWELL_CYCLES < 1 || PWM_BITS < 1 || PWM_DUTY < 0 || PWM_DUTY >= (1 << PWM_BITS)) begin : g_bad_param
    $error("rgb_lut_scan_ctrl: illegal parameter value");
  end
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CAPTURE, DWELL} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sync;
  logic          r_sync_d;
  logic          r_step;
  logic [1:0]    r_dp_a;
  logic [1:0]    r_dp_b;
  logic [3:0]    r_idx;
  logic [15:0]   r_tbl_red;
  logic [15:0]   r_tbl_blue;
  logic [15:0]   r_tbl_green;
  logic [2:0]    r_rgb;
  logic          r_busy;
  logic          r_done;
  logic          w_pwm_on;
  // registered edge detect puts step pulse 3 cycles after the pin edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
      r_step   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], bus.step_btn};
      r_sync_d <= r_sync[1];
      r_step   <= r_sync[1] & ~r_sync_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_idx       <= '0;
      r_tbl_red   <= '0;
      r_tbl_blue  <= '0;
      r_tbl_green <= '0;
      r_rgb       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy && !bus.mode) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE:
            if (!bus.mode) begin
              r_dp_a <= bus.sw_a;
              r_dp_b <= bus.sw_b;
              r_rgb  <= {bus.dp_red, bus.dp_green, bus.dp_blue};
            end else if (r_step) begin
              r_state <= DRIVE;
              r_idx   <= '0;
              r_busy  <= 1'b1;
            end
          DRIVE: begin
            r_dp_a  <= r_idx[3:2];
            r_dp_b  <= r_idx[1:0];
            r_cnt   <= CW'(SETTLE_CYCLES - 1);
            r_state <= SETTLE;
          end
          SETTLE:
            if (r_cnt == '0) r_state <= CAPTURE;
            else r_cnt <= r_cnt - 1'b1;
          CAPTURE: begin
            r_tbl_red[r_idx]   <= bus.dp_red;
            r_tbl_blue[r_idx]  <= bus.dp_blue;
            r_tbl_green[r_idx] <= bus.dp_green;
            r_rgb   <= {bus.dp_red, bus.dp_green, bus.dp_blue};
            r_cnt   <= CW'(DWELL_CYCLES - 1);
            r_state <= DWELL;
          end
          DWELL:
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= &r_idx ? IDLE : DRIVE;
              r_busy  <= ~&r_idx;
              r_done  <= &r_idx;
            end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
`ifdef RGB_PWM_EN
  logic [PWM_BITS-1:0] r_pwm_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_cnt <= '0;
    else r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end
  assign w_pwm_on = r_pwm_cnt < PWM_BITS'(PWM_DUTY);
`else
  assign w_pwm_on = 1'b1;
`endif
  assign bus.dp_a      = r_dp_a;
  assign bus.dp_b      = r_dp_b;
  assign bus.led_r     = r_rgb[2] & w_pwm_on;
  assign bus.led_g     = r_rgb[1] & w_pwm_on;
  assign bus.led_b     = r_rgb[0] & w_pwm_on;
  assign bus.busy      = r_busy;
  assign bus.scan_idx  = r_idx;
  assign bus.scan_done = r_done;
  assign bus.tbl_red   = r_tbl_red;
  assign bus.tbl_blue  = r_tbl_blue;
  assign bus.tbl_green = r_tbl_green;
endmodule

// File: tb/tb_rgb_lut_scan_ctrl.sv
// tb_rgb_lut_scan_ctrl: self-checking bench for rgb_lut_scan_ctrl with a LUT-based stub datapath
module tb_rgb_lut_scan_ctrl;
  logic clk;
  logic rst_n;
  logic [15:0] lut_r, lut_g, lut_b;
  logic [15:0] stub_r, stub_g, stub_b;
  int n_tests = 0;
  int n_fail  = 0;
  rgb_lut_scan_ctrl_if bus ();
  rgb_lut_scan_ctrl #(.SETTLE_CYCLES(2), .DWELL_CYCLES(4), .PWM_BITS(4), .PWM_DUTY(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );
  assign bus.dp_red   = lut_r[{bus.dp_a, bus.dp_b}];
  assign bus.dp_green = lut_g[{bus.dp_a, bus.dp_b}];
  assign bus.dp_blue  = lut_b[{bus.dp_a, bus.dp_b}];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] rgb;
  } vec_t;
  vec_t vecs[6];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic chk_led(input string n, input logic [2:0] exp);
`ifdef RGB_PWM_EN
    chk(n, {bus.led_r, bus.led_g, bus.led_b} & ~exp, 0);
`else
    chk(n, {bus.led_r, bus.led_g, bus.led_b}, exp);
`endif
  endtask
  task automatic press();
    bus.step_btn = 1'b1;
    repeat (3) tick();
    chk("busy_before_pulse", bus.busy, 0);
    tick();
    chk("busy_rise", bus.busy, 1);
    bus.step_btn = 1'b0;
  endtask
  // one scan step is SETTLE+DWELL+2 = 8 cycles; k counts cycles after DRIVE is first entered
  task automatic scan(input int abort_k, input bit repress);
    int k;
    bit seen;
    seen = 1'b0;
    press();
    for (k = 1; k <= 200; k++) begin
      tick();
      if (bus.scan_done) break;
      if (k < 128 && k % 8 == 0) chk("scan_idx", bus.scan_idx, k / 8);
      if (k < 128 && k % 8 == 4) chk("scan_dp_ab", {bus.dp_a, bus.dp_b}, k / 8);
      if (repress && k == 44) bus.step_btn = 1'b1;
      if (repress && k == 50) bus.step_btn = 1'b0;
      if (k == abort_k) begin
        bus.mode = 1'b0;
        tick();
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.scan_done, 0);
        repeat (20) begin
          tick();
          if (bus.scan_done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        bus.mode = 1'b1;
        return;
      end
    end
    chk("done_cycle", k, 128);
    chk("done_busy", bus.busy, 0);
    tick();
    chk("done_one_cycle", bus.scan_done, 0);
  endtask
  initial begin
    logic [3:0] prev, cur;
    logic [15:0] old_r, old_g, old_b;
    int on_cnt;
    logic [1:0] ia, ib;
    for (int i = 0; i < 16; i++) begin
      ia = 2'(i >> 2);
      ib = 2'(i & 3);
      stub_r[i] = ia > ib;
      stub_g[i] = ia == ib;
      stub_b[i] = ia < ib;
    end
    lut_r = stub_r;
    lut_g = stub_g;
    lut_b = stub_b;
    vecs[0] = '{2'd2, 2'd1, 3'b100};
    vecs[1] = '{2'd1, 2'd2, 3'b001};
    vecs[2] = '{2'd3, 2'd3, 3'b010};
    vecs[3] = '{2'd0, 2'd3, 3'b001};
    vecs[4] = '{2'd3, 2'd0, 3'b100};
    vecs[5] = '{2'd0, 2'd0, 3'b010};
    rst_n = 1'b0;
    bus.mode = 1'b0;
    bus.step_btn = 1'b0;
    bus.sw_a = 2'd3;
    bus.sw_b = 2'd1;
    repeat (2) tick();
    chk("reset_state", {bus.dp_a, bus.dp_b, bus.scan_idx, bus.busy, bus.scan_done, bus.led_r, bus.led_g, bus.led_b}, 0);
    chk("reset_tbl", {bus.tbl_red, bus.tbl_green, bus.tbl_blue}, 0);
    rst_n = 1'b1;
    tick();
    foreach (vecs[i]) begin
      bus.sw_a = vecs[i].a;
      bus.sw_b = vecs[i].b;
      repeat (2) tick();
      chk("vec_dp", {bus.dp_a, bus.dp_b}, {vecs[i].a, vecs[i].b});
      chk_led("vec_led", vecs[i].rgb);
    end
    bus.step_btn = 1'b1;
    repeat (6) tick();
    chk("manual_step_ignored", bus.busy, 0);
    bus.step_btn = 1'b0;
    lut_r = 16'($urandom);
    lut_g = 16'($urandom);
    lut_b = 16'($urandom);
    cur = 4'($urandom_range(0, 15));
    {bus.sw_a, bus.sw_b} = cur;
    tick();
    for (int n = 0; n < 24; n++) begin
      prev = cur;
      cur = 4'($urandom_range(0, 15));
      {bus.sw_a, bus.sw_b} = cur;
      tick();
      chk("rand_manual_dp", {bus.dp_a, bus.dp_b}, cur);
      chk_led("rand_manual_led", {lut_r[prev], lut_g[prev], lut_b[prev]});
    end
    lut_r = stub_r;
    lut_g = stub_g;
    lut_b = stub_b;
    repeat (4) tick();
    bus.mode = 1'b1;
    scan(-1, 1'b1);
    chk("tbl_green", bus.tbl_green, 16'h8421);
    chk("tbl_red", bus.tbl_red, 16'h7310);
    chk("tbl_blue", bus.tbl_blue, 16'h08CE);
    on_cnt = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      on_cnt += int'(bus.led_g);
      if (bus.led_r | bus.led_b) on_cnt += 100;
    end
`ifdef RGB_PWM_EN
    chk("led_g_on_cycles", on_cnt, 4);
`else
    chk("led_g_on_cycles", on_cnt, 16);
`endif
    lut_r = 16'($urandom);
    lut_g = 16'($urandom);
    lut_b = 16'($urandom);
    repeat (4) tick();
    scan(-1, 1'b0);
    chk("rand_tbl", {bus.tbl_red, bus.tbl_green, bus.tbl_blue}, {lut_r, lut_g, lut_b});
    old_r = lut_r;
    old_g = lut_g;
    old_b = lut_b;
    lut_r = 16'($urandom);
    lut_g = 16'($urandom);
    lut_b = 16'($urandom);
    repeat (4) tick();
    scan(72, 1'b0);
    chk("abort_tbl_red", bus.tbl_red, (lut_r & 16'h01FF) | (old_r & 16'hFE00));
    chk("abort_tbl_green", bus.tbl_green, (lut_g & 16'h01FF) | (old_g & 16'hFE00));
    chk("abort_tbl_blue", bus.tbl_blue, (lut_b & 16'h01FF) | (old_b & 16'hFE00));
    lut_r = stub_r;
    lut_g = stub_g;
    lut_b = stub_b;
    repeat (4) tick();
    press();
    repeat (60) tick();
    chk("pre_reset_idx", bus.scan_idx, 7);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {bus.dp_a, bus.dp_b, bus.scan_idx, bus.busy, bus.scan_done, bus.led_r, bus.led_g, bus.led_b}, 0);
    chk("async_reset_tbl", {bus.tbl_red, bus.tbl_green, bus.tbl_blue}, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_busy", bus.busy, 0);
    chk("post_reset_tbl", {bus.tbl_red, bus.tbl_green, bus.tbl_blue}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
